// File: rtl/scr1_ialu_muldiv_iter.sv
// ---------------------------------------------------------------------------
// scr1_ialu_muldiv_iter
//
// Iterative multiply/divide engine for the RV32M/RV64M extension. It sits
// next to the main adder in the EXU. The EXU issues one command, then waits
// for a one-cycle result strobe. It may abort the command on a pipeline flush.
//
// Multiply: an unsigned shift-add on operand magnitudes, retiring MUL_BITS
//   multiplier bits per cycle. The sign is applied to the 2*XLEN product
//   afterwards.
// Divide: a restoring division on magnitudes, producing DIV_BITS quotient
//   bits per cycle. The quotient and remainder signs are applied afterwards.
// Divide by zero, signed overflow and (optionally) zero-operand multiplies
//   skip the iteration completely. Their result is ready on the accept edge.
//
// Parameters:
//   XLEN       operand/result width (32 or 64)
//   MUL_BITS   multiplier bits per cycle (1, 2 or 4; must divide XLEN)
//   DIV_BITS   quotient bits per cycle (1 or 2; must divide XLEN)
//   EARLY_ZERO 1 = a multiply with a zero operand bypasses iteration
//
// Ports:
//   clk        clock
//   rst_n      asynchronous active-low reset
//   cmd_vd_i   command valid
//   cmd_rdy_o  unit idle; a command is accepted this cycle if cmd_vd_i=1
//   cmd_i      000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//              100 DIV, 101 DIVU, 110 REM,  111 REMU
//   op1_i      rs1 / dividend
//   op2_i      rs2 / divisor
//   kill_i     abort the current operation
//   busy_o     operation in flight
//   res_vd_o   result valid strobe, exactly one cycle
//   res_o      result, held until the next result
// ---------------------------------------------------------------------------
module scr1_ialu_muldiv_iter #(
  parameter int XLEN       = 32,
  parameter int MUL_BITS   = 2,
  parameter int DIV_BITS   = 1,
  parameter int EARLY_ZERO = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_vd_i,
  output logic            cmd_rdy_o,
  input  logic [2:0]      cmd_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            res_vd_o,
  output logic [XLEN-1:0] res_o
);

  localparam int MUL_N = XLEN / MUL_BITS;
  localparam int DIV_N = XLEN / DIV_BITS;
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_N - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_N - 1);
  localparam logic [XLEN-1:0]  XMIN     = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_CORR,
    ST_DONE
  } state_t;

  state_t state_q, state_d;

  // Shared datapath registers.
  // Multiply: acc_q = {partial high, multiplier shifting out}, opb_q = multiplicand.
  // Divide:   acc_q = {remainder, dividend shifting out / quotient shifting in},
  //           opb_q = divisor magnitude.
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opb_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        cmd_q;
  logic              neg_res_q;
  logic              neg_rem_q;

  logic              accept;
  logic              is_div_in;
  logic              a_signed, b_signed;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div0, ovf, mzero, sp_hit;
  logic [XLEN-1:0]   sp_res;

  logic [XLEN+MUL_BITS-1:0] mul_part;
  logic [XLEN+MUL_BITS-1:0] mul_sum;
  logic [2*XLEN-1:0]        mul_next;

  logic [XLEN-1:0]   div_r, div_q;
  logic [XLEN:0]     div_shl;

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, corr_res;

  // A kill in the same cycle blocks acceptance.
  assign accept = (state_q == ST_IDLE) && !kill_i && cmd_vd_i;

  // Operand decoding on the incoming command. For multiply, only the
  // high-half variants have signed operands. Plain MUL uses the unsigned
  // view because its low half does not depend on signedness.
  assign is_div_in = cmd_i[2];
  assign a_signed  = is_div_in ? !cmd_i[0]
                               : (cmd_i[1:0] == 2'b01) || (cmd_i[1:0] == 2'b10);
  assign b_signed  = is_div_in ? !cmd_i[0] : (cmd_i[1:0] == 2'b01);
  assign a_neg     = a_signed && op1_i[XLEN-1];
  assign b_neg     = b_signed && op2_i[XLEN-1];
  assign a_mag     = a_neg ? -op1_i : op1_i;
  assign b_mag     = b_neg ? -op2_i : op2_i;

  // Bypass detection. A zero divisor and signed overflow are handled here,
  // so the iterative divider never sees them.
  assign div0   = is_div_in && (op2_i == '0);
  assign ovf    = is_div_in && !cmd_i[0] && (op1_i == XMIN) && (op2_i == '1);
  assign mzero  = (EARLY_ZERO != 0) && !is_div_in && ((op1_i == '0) || (op2_i == '0));
  assign sp_hit = div0 || ovf || mzero;

  // Bypass result. cmd_i[1] separates REM* from DIV* on the divide side.
  always_comb begin
    sp_res = '0;
    if (div0) begin
      sp_res = cmd_i[1] ? op1_i : '1;
    end else if (ovf) begin
      sp_res = cmd_i[1] ? '0 : op1_i;
    end
  end

  // One shift-add step. The low digit of the multiplier scales the
  // multiplicand. The sum becomes the new high half, and the whole
  // accumulator shifts right by one digit.
  assign mul_part = {{MUL_BITS{1'b0}}, opb_q} * {{XLEN{1'b0}}, acc_q[MUL_BITS-1:0]};
  assign mul_sum  = {{MUL_BITS{1'b0}}, acc_q[2*XLEN-1:XLEN]} + mul_part;
  assign mul_next = {mul_sum, acc_q[XLEN-1:MUL_BITS]};

  // DIV_BITS restoring-division steps chained in one cycle. Each step
  // brings the next dividend bit into the remainder. It subtracts the
  // divisor when it fits, and records the quotient bit in the freed LSB.
  always_comb begin
    div_r   = acc_q[2*XLEN-1:XLEN];
    div_q   = acc_q[XLEN-1:0];
    div_shl = '0;
    for (int i = 0; i < DIV_BITS; i++) begin
      div_shl = {div_r, div_q[XLEN-1]};
      div_q   = {div_q[XLEN-2:0], 1'b0};
      if (div_shl >= {1'b0, opb_q}) begin
        div_shl  = div_shl - {1'b0, opb_q};
        div_q[0] = 1'b1;
      end
      div_r = div_shl[XLEN-1:0];
    end
  end

  // Sign fixup and result selection used in the correction cycle.
  // The quotient is negative when the operand signs differ. The remainder
  // follows the sign of the dividend.
  always_comb begin
    prod_fix = neg_res_q ? -acc_q : acc_q;
    quo_fix  = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (cmd_q[2]) begin
      corr_res = cmd_q[1] ? rem_fix : quo_fix;
    end else begin
      corr_res = (cmd_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs. The strobe is a decode of the DONE
  // state, so a kill arriving during DONE does not suppress it.
  always_comb begin
    state_d   = state_q;
    cmd_rdy_o = 1'b0;
    busy_o    = 1'b0;
    res_vd_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_rdy_o = !kill_i;
        if (accept) begin
          state_d = sp_hit ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        busy_o = 1'b1;
        if (cnt_q == '0) begin
          state_d = ST_CORR;
        end
      end
      ST_CORR: begin
        busy_o  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        busy_o   = 1'b1;
        res_vd_o = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (kill_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end
  end

  // Datapath. Operands are captured on acceptance, then iterated in CALC.
  // The result register changes only on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      opb_q     <= '0;
      cnt_q     <= '0;
      cmd_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      res_o     <= '0;
    end else begin
      if (accept) begin
        cmd_q     <= cmd_i;
        acc_q     <= {{XLEN{1'b0}}, a_mag};
        opb_q     <= b_mag;
        neg_res_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        cnt_q     <= is_div_in ? DIV_LAST : MUL_LAST;
      end else if (state_q == ST_CALC) begin
        acc_q <= cmd_q[2] ? {div_r, div_q} : mul_next;
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end
      if ((state_q == ST_IDLE) && (state_d == ST_DONE)) begin
        res_o <= sp_res;
      end else if ((state_q == ST_CORR) && (state_d == ST_DONE)) begin
        res_o <= corr_res;
      end
    end
  end

endmodule

// File: tb/tb_scr1_ialu_muldiv_iter.sv
// ---------------------------------------------------------------------------
// tb_scr1_ialu_muldiv_iter
//
// Self-checking bench for scr1_ialu_muldiv_iter. It uses two instances:
//   u_dut32 - default parameters (XLEN=32, MUL_BITS=2, DIV_BITS=1)
//   u_dut64 - XLEN=64, MUL_BITS=4, DIV_BITS=2
// Both instances share the command, operand and kill wires. cmd_vd_i is
// steered to the selected instance only, and the outputs are muxed back
// through use64.
//
// Expected results are queued when a command is issued and popped when the
// strobe appears. The 64-bit results come from a direct 128-bit arithmetic
// reference model.
// ---------------------------------------------------------------------------
module tb_scr1_ialu_muldiv_iter;

  localparam logic [2:0] C_MUL    = 3'b000;
  localparam logic [2:0] C_MULH   = 3'b001;
  localparam logic [2:0] C_MULHSU = 3'b010;
  localparam logic [2:0] C_MULHU  = 3'b011;
  localparam logic [2:0] C_DIV    = 3'b100;
  localparam logic [2:0] C_DIVU   = 3'b101;
  localparam logic [2:0] C_REM    = 3'b110;
  localparam logic [2:0] C_REMU   = 3'b111;
  localparam logic [63:0] MIN64   = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES64  = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic        use64;
  logic        cmd_vd;
  logic [2:0]  cmd;
  logic [63:0] op1, op2;
  logic        kill;

  logic        rdy32, busy32, rv32;
  logic [31:0] res32;
  logic        rdy64, busy64, rv64;
  logic [63:0] res64;

  logic        cmd_rdy, busy, res_vd;
  logic [63:0] res;

  int compared;
  int mismatched;
  logic [63:0] sb[$];

  assign cmd_rdy = use64 ? rdy64  : rdy32;
  assign busy    = use64 ? busy64 : busy32;
  assign res_vd  = use64 ? rv64   : rv32;
  assign res     = use64 ? res64  : {32'b0, res32};

  scr1_ialu_muldiv_iter u_dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_vd_i  (cmd_vd && !use64),
    .cmd_rdy_o (rdy32),
    .cmd_i     (cmd),
    .op1_i     (op1[31:0]),
    .op2_i     (op2[31:0]),
    .kill_i    (kill),
    .busy_o    (busy32),
    .res_vd_o  (rv32),
    .res_o     (res32)
  );

  scr1_ialu_muldiv_iter #(
    .XLEN     (64),
    .MUL_BITS (4),
    .DIV_BITS (2)
  ) u_dut64 (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_vd_i  (cmd_vd && use64),
    .cmd_rdy_o (rdy64),
    .cmd_i     (cmd),
    .op1_i     (op1),
    .op2_i     (op2),
    .kill_i    (kill),
    .busy_o    (busy64),
    .res_vd_o  (rv64),
    .res_o     (res64)
  );

  // 100 MHz style free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a wait escapes its own bound.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model written as plain wide arithmetic on the operand
  // encodings.
  function automatic logic [63:0] refModel64(input logic [2:0] c, input logic [63:0] a,
                                             input logic [63:0] b);
    logic [127:0]       ea, eb, p;
    logic signed [63:0] sa, sbv;
    sa  = a;
    sbv = b;
    ea  = ((c == C_MULH) || (c == C_MULHSU)) ? {{64{a[63]}}, a} : {64'b0, a};
    eb  = (c == C_MULH) ? {{64{b[63]}}, b} : {64'b0, b};
    p   = ea * eb;
    case (c)
      C_MUL:                   return p[63:0];
      C_MULH, C_MULHSU, C_MULHU: return p[127:64];
      C_DIV:  return (b == 64'd0) ? ONES64 :
                     ((a == MIN64) && (b == ONES64)) ? a : 64'(sa / sbv);
      C_DIVU: return (b == 64'd0) ? ONES64 : a / b;
      C_REM:  return (b == 64'd0) ? a :
                     ((a == MIN64) && (b == ONES64)) ? 64'd0 : 64'(sa % sbv);
      default: return (b == 64'd0) ? a : a % b;
    endcase
  endfunction

  // Edges from the accept edge to the strobe for the 64-bit instance.
  function automatic int latency64(input logic [2:0] c, input logic [63:0] a,
                                   input logic [63:0] b);
    if (c[2]) begin
      return ((b == 64'd0) || (!c[0] && (a == MIN64) && (b == ONES64))) ? 0 : 33;
    end
    return ((a == 64'd0) || (b == 64'd0)) ? 0 : 17;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
    end
  endtask

  // Presents one command at a negedge and holds it through the accept edge.
  // Afterwards the operand wires are scrambled to show they are not re-read.
  task automatic acceptOnly(input bit w64, input logic [2:0] c, input logic [63:0] a,
                            input logic [63:0] b);
    @(negedge clk);
    use64  = w64;
    cmd_vd = 1'b1;
    cmd    = c;
    op1    = a;
    op2    = b;
    #1;
    checkOutput("cmd_rdy_idle", 64'(cmd_rdy), 64'd1);
    @(posedge clk);
    #1;
    cmd_vd = 1'b0;
    op1    = {$urandom, $urandom};
    op2    = {$urandom, $urandom};
    cmd    = 3'($urandom_range(0, 7));
  endtask

  // Waits for the strobe within a bounded number of edges, then checks
  // latency, ready behaviour, the popped result and the one-cycle strobe.
  task automatic waitResult(input int lat);
    int          edges;
    bit          rdy_low;
    logic [63:0] exp;
    edges   = 0;
    rdy_low = 1'b1;
    exp     = 'x;
    while (!res_vd && (edges < 200)) begin
      if (cmd_rdy) rdy_low = 1'b0;
      @(posedge clk);
      #1;
      edges++;
    end
    if (cmd_rdy) rdy_low = 1'b0;
    checkOutput("strobe_seen", 64'(res_vd), 64'd1);
    checkOutput("latency", 64'(edges), 64'(lat));
    checkOutput("rdy_low_while_busy", 64'(rdy_low), 64'd1);
    if (sb.size() > 0) exp = sb.pop_front();
    checkOutput("result", res, exp);
    @(posedge clk);
    #1;
    checkOutput("strobe_one_cycle", 64'(res_vd), 64'd0);
    checkOutput("rdy_after_done", 64'(cmd_rdy), 64'd1);
    checkOutput("result_held", res, exp);
  endtask

  task automatic applyStimulus(input bit w64, input logic [2:0] c, input logic [63:0] a,
                               input logic [63:0] b, input logic [63:0] exp,
                               input int lat);
    sb.push_back(exp);
    acceptOnly(w64, c, a, b);
    waitResult(lat);
  endtask

  initial begin
    logic [2:0]  rc;
    logic [63:0] ra, rb;
    int          strobes;

    compared   = 0;
    mismatched = 0;
    use64      = 1'b0;
    cmd_vd     = 1'b0;
    cmd        = 3'b000;
    op1        = '0;
    op2        = '0;
    kill       = 1'b0;
    rst_n      = 1'b0;

    // Reset values on both instances.
    #12;
    checkOutput("reset_busy32", 64'(busy), 64'd0);
    checkOutput("reset_rv32", 64'(res_vd), 64'd0);
    checkOutput("reset_res32", res, 64'd0);
    checkOutput("reset_rdy32", 64'(cmd_rdy), 64'd1);
    use64 = 1'b1;
    #1;
    checkOutput("reset_busy64", 64'(busy), 64'd0);
    checkOutput("reset_res64", res, 64'd0);
    checkOutput("reset_rdy64", 64'(cmd_rdy), 64'd1);
    use64 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // 32-bit multiplies: 16 iterations plus correction.
    applyStimulus(0, C_MUL,    64'h7,        64'h6,        64'h0000_002A, 17);
    applyStimulus(0, C_MULH,   64'h8000_0000, 64'h8000_0000, 64'h4000_0000, 17);
    applyStimulus(0, C_MULHSU, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 17);
    applyStimulus(0, C_MULHU,  64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 17);

    // 32-bit divides: 32 iterations plus correction.
    applyStimulus(0, C_DIV,  64'hFFFF_FFF9, 64'h2, 64'hFFFF_FFFD, 33);
    applyStimulus(0, C_REM,  64'hFFFF_FFF9, 64'h2, 64'hFFFF_FFFF, 33);
    applyStimulus(0, C_DIVU, 64'd100,       64'd7, 64'd14,        33);
    applyStimulus(0, C_REMU, 64'd100,       64'd7, 64'd2,         33);

    // Bypass cases: the strobe is visible right after the accept edge.
    applyStimulus(0, C_DIVU, 64'd5, 64'd0, 64'hFFFF_FFFF, 0);
    applyStimulus(0, C_REMU, 64'd5, 64'd0, 64'd5,         0);
    applyStimulus(0, C_DIV,  64'd5, 64'd0, 64'hFFFF_FFFF, 0);
    applyStimulus(0, C_DIV,  64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 0);
    applyStimulus(0, C_REM,  64'h8000_0000, 64'hFFFF_FFFF, 64'd0,         0);
    applyStimulus(0, C_MUL,  64'd0,         64'h1234,      64'd0,         0);
    applyStimulus(0, C_MULHU, 64'h1234,     64'd0,         64'd0,         0);

    // Kill together with a valid command in IDLE: nothing is accepted.
    @(negedge clk);
    use64  = 1'b0;
    kill   = 1'b1;
    cmd_vd = 1'b1;
    cmd    = C_MUL;
    op1    = 64'd3;
    op2    = 64'd3;
    #1;
    checkOutput("rdy_blocked_by_kill", 64'(cmd_rdy), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("no_accept_under_kill", 64'(busy), 64'd0);
    @(negedge clk);
    cmd_vd = 1'b0;
    kill   = 1'b0;

    // Kill five cycles into a divide: back to idle, no strobe.
    acceptOnly(0, C_DIV, 64'd100, 64'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("kill_idle_next", 64'(busy), 64'd0);
    checkOutput("kill_no_strobe", 64'(res_vd), 64'd0);
    @(negedge clk);
    kill = 1'b0;
    strobes = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (res_vd) strobes++;
    end
    checkOutput("no_late_strobe", 64'(strobes), 64'd0);
    applyStimulus(0, C_MUL, 64'd3, 64'd3, 64'd9, 17);

    // Reset dropped mid-multiply, between clock edges.
    acceptOnly(0, C_MUL, 64'd5, 64'd5);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", 64'(busy), 64'd0);
    checkOutput("midreset_rv", 64'(res_vd), 64'd0);
    checkOutput("midreset_res", res, 64'd0);
    checkOutput("midreset_rdy", 64'(cmd_rdy), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    strobes = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (res_vd) strobes++;
    end
    checkOutput("no_strobe_after_reset", 64'(strobes), 64'd0);

    // 64-bit instance: directed corners.
    applyStimulus(1, C_MULH, MIN64, MIN64, 64'h4000_0000_0000_0000, 17);
    applyStimulus(1, C_DIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    applyStimulus(1, C_REM,  MIN64, ONES64, 64'd0, 0);
    applyStimulus(1, C_DIVU, 64'd77, 64'd0, ONES64, 0);

    // 64-bit instance: random commands checked against the reference model.
    for (int n = 0; n < 48; n++) begin
      rc = 3'($urandom_range(0, 7));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        1: rb = 64'($urandom_range(1, 1000));
        2: rb = -64'($urandom_range(1, 1000));
        3: ra = 64'($urandom_range(0, 5000));
        default: ;
      endcase
      applyStimulus(1, rc, ra, rb, refModel64(rc, ra, rb), latency64(rc, ra, rb));
    end

    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
